running_man_ctrl: RTL and testbench

- Control FSM directly upstream of the running-man drawing datapath.
- Sequences one-time floor drawing, then a draw / hold / erase / update loop per frame.
- Drives the datapath's request strobes, sprite origin and pose, and consumes its finish flags.
- Advances the man along the three floor lanes and counts completed laps.

---
 rtl/running_man_ctrl.sv | 147 ++++++++++++++
 tb/tb_running_man_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/running_man_ctrl.sv
// Control FSM for the running-man drawing datapath: one-time floor draw, then a
// per-frame draw / hold / erase / update loop that walks the sprite across three lanes.
module running_man_ctrl #(
    parameter int FRAME_TICKS = 833333,
    parameter int STEP        = 1,
    parameter int X_MAX       = 153
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       crouch_key,
    input  logic       draw_floors_finish,
    input  logic       draw_man_finish,
    input  logic       erase_finish,
    output logic       drawing_floors,
    output logic       draw_man,
    output logic       erase,
    output logic       plot,
    output logic [7:0] x_original,
    output logic [6:0] y_original,
    output logic       normal1crouch0,
    output logic [7:0] laps
);
    localparam int              CW       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(FRAME_TICKS - 1);
    localparam logic [8:0]      STEP9    = 9'(STEP);
    localparam logic [8:0]      XMAX9    = 9'(X_MAX);
    localparam logic [6:0]      Y_LANE0  = 7'd28;
    localparam logic [6:0]      Y_LANE1  = 7'd68;
    localparam logic [6:0]      Y_LANE2  = 7'd108;

    typedef enum logic [2:0] {
        S_FLOORS,
        S_DRAW,
        S_HOLD,
        S_ERASE,
        S_UPDATE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic            pose_q, pose_d;
    logic [7:0]      laps_q, laps_d;
    logic            floors_req_q, floors_req_d;
    logic            man_req_q, man_req_d;
    logic            erase_req_q, erase_req_d;
    logic [2:0]      fin_prev_q;
    logic [2:0]      fin_now;
    logic [2:0]      done;
    logic [8:0]      x_sum;

    // Only a rising edge of a finish level counts, so a flag left high by the
    // datapath from an earlier request can never complete a new one.
    assign fin_now = {draw_floors_finish, draw_man_finish, erase_finish};
    assign done    = fin_now & ~fin_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        pose_d  = pose_q;
        laps_d  = laps_q;
        x_sum   = {1'b0, x_q} + STEP9;
        case (state_q)
            S_FLOORS: begin
                if (done[2]) state_d = S_DRAW;
            end
            S_DRAW: begin
                if (done[1]) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ERASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERASE: begin
                if (done[0]) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = S_DRAW;
                pose_d  = ~crouch_key;
                if (x_sum <= XMAX9) begin
                    x_d = x_sum[7:0];
                end else begin
                    x_d = '0;
                    case (y_q)
                        Y_LANE0: y_d = Y_LANE1;
                        Y_LANE1: y_d = Y_LANE2;
                        default: begin
                            y_d = Y_LANE0;
                            if (laps_q != 8'hFF) laps_d = laps_q + 8'd1;
                        end
                    endcase
                end
            end
            default: state_d = S_FLOORS;
        endcase
        // Requests follow the next state so they are high from the first cycle in it.
        floors_req_d = (state_d == S_FLOORS);
        man_req_d    = (state_d == S_DRAW);
        erase_req_d  = (state_d == S_ERASE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FLOORS;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= Y_LANE0;
            pose_q       <= 1'b1;
            laps_q       <= '0;
            floors_req_q <= 1'b0;
            man_req_q    <= 1'b0;
            erase_req_q  <= 1'b0;
            fin_prev_q   <= fin_now;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pose_q       <= pose_d;
            laps_q       <= laps_d;
            floors_req_q <= floors_req_d;
            man_req_q    <= man_req_d;
            erase_req_q  <= erase_req_d;
            fin_prev_q   <= fin_now;
        end
    end

    assign drawing_floors = floors_req_q;
    assign draw_man       = man_req_q;
    assign erase          = erase_req_q;
    assign plot           = floors_req_q | man_req_q | erase_req_q;
    assign x_original     = x_q;
    assign y_original     = y_q;
    assign normal1crouch0 = pose_q;
    assign laps           = laps_q;

endmodule

// File: tb/tb_running_man_ctrl.sv
// Bench for running_man_ctrl: per-cycle vector table on a short-hold instance, then
// frame-level sequences for lane wrap, reset mid-erase, and lap saturation on a tiny-lane instance.
module tb_running_man_ctrl;
    logic       clk = 1'b0;
    logic       rst [2];
    logic       cr  [2];
    logic       ff  [2];
    logic       mf  [2];
    logic       ef  [2];
    logic       df_o [2];
    logic       dm_o [2];
    logic       er_o [2];
    logic       pl_o [2];
    logic [7:0] x_o  [2];
    logic [6:0] y_o  [2];
    logic       n_o  [2];
    logic [7:0] lp_o [2];

    int n_cmp = 0;
    int n_bad = 0;
    int x_m [2];
    int y_m [2];
    int lp_m [2];
    int n_m [2];

    always #5 clk = ~clk;

    running_man_ctrl #(.FRAME_TICKS(4), .STEP(1), .X_MAX(153)) dut0 (
        .clk(clk), .reset(rst[0]), .crouch_key(cr[0]),
        .draw_floors_finish(ff[0]), .draw_man_finish(mf[0]), .erase_finish(ef[0]),
        .drawing_floors(df_o[0]), .draw_man(dm_o[0]), .erase(er_o[0]), .plot(pl_o[0]),
        .x_original(x_o[0]), .y_original(y_o[0]), .normal1crouch0(n_o[0]), .laps(lp_o[0])
    );

    running_man_ctrl #(.FRAME_TICKS(1), .STEP(1), .X_MAX(1)) dut1 (
        .clk(clk), .reset(rst[1]), .crouch_key(cr[1]),
        .draw_floors_finish(ff[1]), .draw_man_finish(mf[1]), .erase_finish(ef[1]),
        .drawing_floors(df_o[1]), .draw_man(dm_o[1]), .erase(er_o[1]), .plot(pl_o[1]),
        .x_original(x_o[1]), .y_original(y_o[1]), .normal1crouch0(n_o[1]), .laps(lp_o[1])
    );

    typedef struct {
        logic rst, crouch, ff, mf, ef;
        logic df, dm, er;
        int   x, y;
        logic n;
    } vec_t;

    vec_t tbl [33];

    function automatic vec_t mk(input logic r, c, f, m, e, d0, d1, d2,
                                input int x, y, input logic n);
        vec_t v;
        v.rst = r; v.crouch = c; v.ff = f; v.mf = m; v.ef = e;
        v.df = d0; v.dm = d1; v.er = d2; v.x = x; v.y = y; v.n = n;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected effect of one UPDATE edge.
    task automatic model_update(input int s, input int xmax, input logic crouch);
        n_m[s] = crouch ? 0 : 1;
        if (x_m[s] + 1 <= xmax) begin
            x_m[s] = x_m[s] + 1;
        end else begin
            x_m[s] = 0;
            if (y_m[s] == 28) y_m[s] = 68;
            else if (y_m[s] == 68) y_m[s] = 108;
            else begin
                y_m[s] = 28;
                if (lp_m[s] < 255) lp_m[s] = lp_m[s] + 1;
            end
        end
    endtask

    // Starts in DRAW; pulses man done, waits for erase, pulses erase done, ends back in DRAW.
    task automatic run_frame(input int s, input int xmax, input logic crouch);
        int guard;
        mf[s] = 1'b0; ef[s] = 1'b0;
        tick();
        mf[s] = 1'b1;
        tick();
        guard = 0;
        while (er_o[s] !== 1'b1 && guard < 64) begin
            tick();
            guard++;
        end
        chk($sformatf("erase_wait%0d", s), int'(guard < 64), 1);
        ef[s] = 1'b1;
        tick();
        chk($sformatf("update_plot%0d", s), int'(pl_o[s]), 0);
        cr[s] = crouch; ef[s] = 1'b0;
        tick();
        model_update(s, xmax, crouch);
        chk($sformatf("frame_dm%0d", s), int'(dm_o[s]), 1);
        chk($sformatf("frame_x%0d", s), int'(x_o[s]), x_m[s]);
        chk($sformatf("frame_y%0d", s), int'(y_o[s]), y_m[s]);
        chk($sformatf("frame_laps%0d", s), int'(lp_o[s]), lp_m[s]);
        chk($sformatf("frame_pose%0d", s), int'(n_o[s]), n_m[s]);
        $display("frame dut%0d: x=%0d y=%0d pose=%0d laps=%0d", s, x_o[s], y_o[s], n_o[s], lp_o[s]);
    endtask

    initial begin
        int frames;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; cr[s] = 1'b0; ff[s] = 1'b0; mf[s] = 1'b0; ef[s] = 1'b0;
        end
        mf[0] = 1'b1;

        for (int i = 0; i < 3; i++)  tbl[i] = mk(1,0,0,1,0, 0,0,0, 0,28,1);
        for (int i = 3; i < 12; i++) tbl[i] = mk(0,0,0,1,0, 1,0,0, 0,28,1);
        tbl[12] = mk(0,0,1,1,0, 0,1,0, 0,28,1);
        tbl[13] = mk(0,0,0,1,0, 0,1,0, 0,28,1);
        tbl[14] = mk(0,0,1,1,0, 0,1,0, 0,28,1);
        tbl[15] = mk(0,0,0,0,0, 0,1,0, 0,28,1);
        tbl[16] = mk(0,0,0,1,0, 0,0,0, 0,28,1);
        tbl[17] = mk(0,0,0,1,1, 0,0,0, 0,28,1);
        tbl[18] = mk(0,0,0,1,1, 0,0,0, 0,28,1);
        tbl[19] = mk(0,0,0,1,1, 0,0,0, 0,28,1);
        tbl[20] = mk(0,0,0,1,1, 0,0,1, 0,28,1);
        tbl[21] = mk(0,0,0,1,1, 0,0,1, 0,28,1);
        tbl[22] = mk(0,0,0,1,0, 0,0,1, 0,28,1);
        tbl[23] = mk(0,1,0,1,1, 0,0,0, 0,28,1);
        tbl[24] = mk(0,1,0,1,1, 0,1,0, 1,28,0);
        tbl[25] = mk(0,0,0,0,1, 0,1,0, 1,28,0);
        tbl[26] = mk(0,0,0,1,1, 0,0,0, 1,28,0);
        tbl[27] = mk(0,0,0,1,1, 0,0,0, 1,28,0);
        tbl[28] = mk(0,0,0,1,1, 0,0,0, 1,28,0);
        tbl[29] = mk(0,0,0,1,1, 0,0,0, 1,28,0);
        tbl[30] = mk(0,0,0,1,0, 0,0,1, 1,28,0);
        tbl[31] = mk(0,0,0,1,1, 0,0,0, 1,28,0);
        tbl[32] = mk(0,0,0,1,0, 0,1,0, 2,28,1);

        for (int i = 0; i < 33; i++) begin
            rst[0] = tbl[i].rst; cr[0] = tbl[i].crouch;
            ff[0] = tbl[i].ff; mf[0] = tbl[i].mf; ef[0] = tbl[i].ef;
            tick();
            chk($sformatf("v%0d.df", i), int'(df_o[0]), int'(tbl[i].df));
            chk($sformatf("v%0d.dm", i), int'(dm_o[0]), int'(tbl[i].dm));
            chk($sformatf("v%0d.er", i), int'(er_o[0]), int'(tbl[i].er));
            chk($sformatf("v%0d.plot", i), int'(pl_o[0]), int'(tbl[i].df | tbl[i].dm | tbl[i].er));
            chk($sformatf("v%0d.x", i), int'(x_o[0]), tbl[i].x);
            chk($sformatf("v%0d.y", i), int'(y_o[0]), tbl[i].y);
            chk($sformatf("v%0d.pose", i), int'(n_o[0]), int'(tbl[i].n));
            chk($sformatf("v%0d.laps", i), int'(lp_o[0]), 0);
            $display("vec %0d: df=%0d dm=%0d er=%0d plot=%0d x=%0d y=%0d pose=%0d",
                     i, df_o[0], dm_o[0], er_o[0], pl_o[0], x_o[0], y_o[0], n_o[0]);
        end

        // Walk through all three lanes until the first lap completes.
        x_m[0] = 2; y_m[0] = 28; lp_m[0] = 0; n_m[0] = 1;
        frames = 0;
        while (lp_m[0] == 0 && frames < 600) begin
            run_frame(0, 153, frames[3]);
            frames++;
        end
        chk("lap1_laps", int'(lp_o[0]), 1);
        chk("lap1_x", int'(x_o[0]), 0);
        chk("lap1_y", int'(y_o[0]), 28);

        // Reset in the middle of ERASE.
        mf[0] = 1'b0; tick();
        mf[0] = 1'b1; tick();
        frames = 0;
        while (er_o[0] !== 1'b1 && frames < 64) begin
            tick();
            frames++;
        end
        chk("rst_erase_wait", int'(frames < 64), 1);
        rst[0] = 1'b1; cr[0] = 1'b1;
        tick();
        chk("rst_mid.er", int'(er_o[0]), 0);
        chk("rst_mid.df", int'(df_o[0]), 0);
        chk("rst_mid.plot", int'(pl_o[0]), 0);
        chk("rst_mid.x", int'(x_o[0]), 0);
        chk("rst_mid.y", int'(y_o[0]), 28);
        chk("rst_mid.pose", int'(n_o[0]), 1);
        chk("rst_mid.laps", int'(lp_o[0]), 0);
        rst[0] = 1'b0;
        tick();
        chk("rst_rel.df", int'(df_o[0]), 1);
        $display("reset mid-erase: df=%0d x=%0d y=%0d pose=%0d", df_o[0], x_o[0], y_o[0], n_o[0]);

        // Tiny-lane instance: 6 frames per lap, run 256 laps to hit saturation.
        rst[1] = 1'b0;
        tick();
        chk("sat_start.df", int'(df_o[1]), 1);
        ff[1] = 1'b1;
        tick();
        chk("sat_start.dm", int'(dm_o[1]), 1);
        x_m[1] = 0; y_m[1] = 28; lp_m[1] = 0; n_m[1] = 1;
        for (int f = 0; f < 1536; f++) begin
            run_frame(1, 1, f[0]);
        end
        chk("sat_final_laps", int'(lp_o[1]), 255);
        chk("sat_final_y", int'(y_o[1]), 28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
